// File: rtl/sched_assign_ctrl.sv
// Delayed-assignment scheduler: captures a value at acceptance and commits it to q
// a programmable number of cycles later, with transport or inertial discipline.
module sched_assign_ctrl #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_data,
  input  logic [CNT_W-1:0]           req_delay,
  input  logic                       mode,
  output logic [WIDTH-1:0]           q,
  output logic                       commit,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt
);
  localparam int PC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [CNT_W-1:0] cnt_reg [DEPTH];
  // older_reg[i][j] is set when slot i holds an older request than slot j
  logic [DEPTH-1:0] older_reg [DEPTH];
  logic [WIDTH-1:0] q_reg, q_next;
  logic             commit_reg;
  logic [PC_W-1:0]  pending_cnt_reg, pending_cnt_next;

  logic             accept;
  logic             slot_found;
  logic [DEPTH-1:0] expire, flush, win, load_sel, valid_next;

  assign req_ready   = rst_n & (mode | (pending_cnt_reg != PC_W'(DEPTH)));
  assign accept      = req_valid & req_ready;
  assign q           = q_reg;
  assign commit      = commit_reg;
  assign pending_cnt = pending_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign expire[gi]     = valid_reg[gi] & (cnt_reg[gi] == '0);
      assign flush[gi]      = accept & mode & valid_reg[gi] & ~expire[gi];
      assign valid_next[gi] = (valid_reg[gi] & ~expire[gi] & ~flush[gi]) | load_sel[gi];
    end
  endgenerate

  // An expiring slot wins q only if no other expiring slot is younger.
  always_comb begin
    win = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win[i] = expire[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && expire[j] && older_reg[i][j]) begin
          win[i] = 1'b0;
        end
      end
    end
  end

  // Prefer a slot that is already empty; a slot released at this edge is only
  // reused when nothing else is free (inertial acceptance on a full table).
  always_comb begin
    load_sel   = '0;
    slot_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!slot_found && !valid_reg[i]) begin
        load_sel[i] = 1'b1;
        slot_found  = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!slot_found && (expire[i] || flush[i])) begin
        load_sel[i] = 1'b1;
        slot_found  = 1'b1;
      end
    end
    if (!accept) begin
      load_sel = '0;
    end
  end

  always_comb begin
    q_next = q_reg;
    for (int i = 0; i < DEPTH; i++) begin
      if (win[i]) begin
        q_next = data_reg[i];
      end
    end
  end

  always_comb begin
    pending_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_cnt_next = pending_cnt_next + PC_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg       <= '0;
      q_reg           <= '0;
      commit_reg      <= 1'b0;
      pending_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_reg[i]  <= '0;
        cnt_reg[i]   <= '0;
        older_reg[i] <= '0;
      end
    end else begin
      valid_reg       <= valid_next;
      q_reg           <= q_next;
      commit_reg      <= |expire;
      pending_cnt_reg <= pending_cnt_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (load_sel[i]) begin
          data_reg[i]  <= req_data;
          cnt_reg[i]   <= req_delay;
          older_reg[i] <= '0;
        end else begin
          if (valid_reg[i] && cnt_reg[i] != '0) begin
            cnt_reg[i] <= cnt_reg[i] - CNT_W'(1);
          end
          // every other slot becomes older than the newly loaded one
          older_reg[i] <= older_reg[i] | load_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_sched_assign_ctrl.sv
// Bench for sched_assign_ctrl: directed vector table, corner-case sequences and a
// random run, all checked against a due-edge scoreboard.
module tb_sched_assign_ctrl;
  localparam int WIDTH = 1;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int PC_W  = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [CNT_W-1:0] req_delay;
  logic             mode;
  logic [WIDTH-1:0] q;
  logic             commit;
  logic [PC_W-1:0]  pending_cnt;

  always #5 clk = ~clk;

  sched_assign_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_delay(req_delay), .mode(mode),
    .q(q), .commit(commit), .pending_cnt(pending_cnt)
  );

  typedef struct { int due; logic [WIDTH-1:0] val; } ent_t;
  typedef struct {
    logic rn; logic v; logic [WIDTH-1:0] d; logic [CNT_W-1:0] dly; logic m;
    logic [WIDTH-1:0] q; logic c; logic [PC_W-1:0] pc;
  } vec_t;

  ent_t             sb[$];
  vec_t             tbl[$];
  logic [WIDTH-1:0] exp_q;
  logic             exp_commit;
  logic             last_acc;
  int               edge_n;
  int               commit_seen;
  int               n_pass = 0;
  int               n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  // One clock: check ready, take the edge, update the scoreboard, check outputs.
  task automatic cycle();
    logic exp_ready;
    int   i;
    ent_t e;
    #1;
    exp_ready = rst_n && (mode || sb.size() != DEPTH);
    chk("req_ready", req_ready, exp_ready);
    last_acc = req_valid && exp_ready;
    @(posedge clk);
    edge_n++;
    exp_commit = 1'b0;
    if (!rst_n) begin
      sb.delete();
      exp_q = '0;
    end else begin
      if (last_acc && mode) begin
        i = 0;
        while (i < sb.size()) begin
          if (sb[i].due > edge_n) sb.delete(i);
          else i++;
        end
      end
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].due == edge_n) begin
          exp_q      = sb[i].val;
          exp_commit = 1'b1;
          sb.delete(i);
        end else begin
          i++;
        end
      end
      if (last_acc) begin
        e.due = edge_n + int'(req_delay) + 1;
        e.val = req_data;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    if (commit === 1'b1) commit_seen++;
    chk("sb_q", q, exp_q);
    chk("sb_commit", commit, exp_commit);
    chk("sb_pending", pending_cnt, sb.size());
    $display("edge %0d: rst_n=%0b valid=%0b acc=%0b data=%0d dly=%0d mode=%0b -> q=%0d commit=%0b pend=%0d",
             edge_n, rst_n, req_valid, last_acc, req_data, req_delay, mode, q, commit, pending_cnt);
  endtask

  task automatic add(input logic rn, input logic v, input logic [WIDTH-1:0] d,
                     input logic [CNT_W-1:0] dly, input logic m,
                     input logic [WIDTH-1:0] eq, input logic ec, input logic [PC_W-1:0] epc);
    vec_t t;
    t.rn = rn; t.v = v; t.d = d; t.dly = dly; t.m = m;
    t.q = eq; t.c = ec; t.pc = epc;
    tbl.push_back(t);
  endtask

  task automatic idle(input logic [WIDTH-1:0] eq, input logic ec, input logic [PC_W-1:0] epc);
    add(1'b1, 1'b0, '0, '0, 1'b0, eq, ec, epc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_edge;
    int acc_edge;
    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_delay = '0; mode = 1'b0;
    edge_n = 0; exp_q = '0; exp_commit = 1'b0; last_acc = 1'b0; commit_seen = 0;

    // reset, then D=0 latency
    add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    add(1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    idle(1'b1, 1'b1, 3'd0);
    // two requests expiring on the same edge: youngest (0) wins
    add(1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 3'd2);
    idle(1'b1, 1'b0, 3'd2);
    idle(1'b1, 1'b0, 3'd2);
    idle(1'b0, 1'b1, 3'd0);
    idle(1'b0, 1'b0, 3'd0);
    // inertial request cancels a long transport one
    add(1'b1, 1'b1, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 3'd1);
    idle(1'b0, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 3'd1);
    idle(1'b0, 1'b0, 3'd1);
    idle(1'b0, 1'b0, 3'd1);
    idle(1'b1, 1'b1, 3'd0);
    for (int k = 0; k < 7; k++) idle(1'b1, 1'b0, 3'd0);
    // inertial accept on the edge an older slot expires: that slot still commits
    add(1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 3'd1);
    idle(1'b1, 1'b0, 3'd1);
    add(1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 3'd1);
    idle(1'b1, 1'b1, 3'd0);
    idle(1'b1, 1'b0, 3'd0);
    // reset mid-flight discards the pending update
    add(1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 3'd1);
    add(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) idle(1'b0, 1'b0, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rn; req_valid = tbl[i].v; req_data = tbl[i].d;
      req_delay = tbl[i].dly; mode = tbl[i].m;
      cycle();
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_commit", i), commit, tbl[i].c);
      chk($sformatf("tbl%0d_pending", i), pending_cnt, tbl[i].pc);
    end

    // data sampled at acceptance, later changes ignored
    req_valid = 1'b1; req_data = 1'b1; req_delay = 5'd5; mode = 1'b0;
    cycle();
    req_valid = 1'b0; req_data = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("hold_q", q, 1'b0);
      chk("hold_commit", commit, 1'b0);
    end
    cycle();
    chk("sampled_q", q, 1'b1);
    chk("sampled_commit", commit, 1'b1);

    // transport: fill the table, stall, then resume after the first expiry
    commit_seen = 0;
    first_edge = 0;
    for (int k = 0; k < DEPTH; k++) begin
      req_valid = 1'b1; req_data = (k % 2 == 0) ? 1'b0 : 1'b1; req_delay = 5'd20; mode = 1'b0;
      cycle();
      if (k == 0) first_edge = edge_n;
    end
    chk("full_pending", pending_cnt, DEPTH);
    req_valid = 1'b1; req_data = 1'b1; req_delay = 5'd20; mode = 1'b0;
    #1;
    chk("full_ready", req_ready, 1'b0);
    acc_edge = -1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_acc) begin
        acc_edge = edge_n;
        break;
      end
    end
    req_valid = 1'b0;
    chk("stall_accept_edge", acc_edge - first_edge, 22);
    for (int k = 0; k < 30; k++) cycle();
    chk("stall_commits", commit_seen, 5);

    // random mix of transport and inertial traffic
    for (int k = 0; k < 300; k++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_data  = WIDTH'($urandom_range(0, 1));
      req_delay = CNT_W'($urandom_range(0, 7));
      mode      = ($urandom_range(0, 4) == 0);
      cycle();
    end
    req_valid = 1'b0; mode = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    chk("drain_pending", pending_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sched_assign_ctrl.md
Name: sched_assign_ctrl

Overview:
Delayed-assignment scheduler. Captures a request value at acceptance and commits it to a registered output a programmable number of cycles later, so intra-assignment delay is modelled in synthesizable hardware. It has two scheduling disciplines. Transport mode keeps every pending update, like stacked non-blocking delayed assignments. Inertial mode cancels older pending updates when a new one arrives. It sits in front of the comb_ckts OR-style datapath and sequences when that datapath's result register is updated.

Parameters:
WIDTH, 1, data width of scheduled value
DEPTH, 4, number of pending-update slots (>=2)
CNT_W, 5, width of delay field; max delay 2^CNT_W-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request can be accepted this cycle (combinational)
req_data  input  WIDTH  value sampled at acceptance edge
req_delay  input  CNT_W  delay D in cycles, sampled at acceptance
mode  input  1  0 = transport, 1 = inertial; sampled only at acceptance
q  output  WIDTH  committed value (registered)
commit  output  1  one-cycle pulse: q updated at this edge
pending_cnt  output  $clog2(DEPTH+1)  occupied slots (registered)

Behaviour:
- Reset: on an edge with rst_n=0, all slots are cleared and q=0, commit=0, pending_cnt=0. req_ready=0 while rst_n=0. Reset mid-operation discards all pending updates; none commit afterwards.
- Acceptance: occurs at an edge where req_valid & req_ready. req_ready = rst_n & (mode | (pending_cnt != DEPTH)), based on the registered count only. A slot freed at the same edge does not raise req_ready early.
- Slot load: the accepted request goes into the lowest-index free slot with data=req_data, cnt=req_delay, and a sequence tag that is younger than all live slots.
- Countdown: each live slot with cnt != 0 decrements at every edge.
- Expiry: a live slot with cnt == 0 at an edge expires at that edge. It frees its slot, loads q, and asserts commit for the following cycle.
- Latency: a request accepted at edge N with delay D updates q at edge N+D+1. D=0 gives q at edge N+1. Minimum latency is 1; there is no combinational bypass.
- Data sampling: req_data changes after acceptance have no effect on the scheduled value.
- Multiple expiries at one edge: the youngest tag wins q. All expiring slots free. commit=1 (single pulse).
- Transport mode: all slots are retained independently. A full table (pending_cnt==DEPTH) stalls the requester via req_ready=0.
- Inertial mode: acceptance flushes every live slot that is not expiring at that edge, then loads the new request. pending_cnt becomes 1, or 1 plus nothing if the flushed slots expired. A slot expiring at the same edge as the flush still commits. The mode bit is per request: a later transport request does not restore flushed slots.
- Simultaneous accept and expiry in transport mode: both happen. The new slot may reuse an index freed at the same edge only if no other slot is free; the freed index is available from the next edge.
- pending_cnt update: pending_cnt(next) = pending_cnt − expiries + accept − flushed. It never exceeds DEPTH and never underflows.
- Tags: relative age is maintained in an age matrix or wrapped counter. Order must stay correct indefinitely; tag wrap-around must not invert age between live slots.
- No X output: q and commit are fully defined after the first reset edge.

Test Plan:
- Reset then latency: reset for 2 edges. Accept data=1, D=0, mode=0 at edge 3 -> q=1 and commit=1 at edge 4; pending_cnt 1→0.
- Sample-at-accept: accept data=1, D=5 at edge 10, then drive req_data=0 from edge 11 -> q=1 at edge 16. q is unchanged at edges 11–15.
- Transport full/stall with DEPTH=4: accept D=20 four times at edges 1–4 -> pending_cnt=4, req_ready=0. The 5th req_valid is held until the first expiry at edge 22; req_ready=1 in the cycle after; 5 commits total in order.
- Inertial cancel: accept data=1, D=10 at edge 1 (transport), then accept data=0, D=3, mode=1 at edge 5 -> the first update never commits. q=0 at edge 9 is the only commit; pending_cnt=1 after edge 5.
- Same-edge expiry: accept data=1, D=4 at edge 1 and data=0, D=3 at edge 2 -> both expire at edge 6. q=0 (youngest wins), commit is a single pulse, pending_cnt=0.
- Reset mid-flight: accept D=8 at edge 1 and assert rst_n=0 at edge 4 -> q stays 0, no commit through edge 15, pending_cnt=0.
